seq_signed_unsigned_divider: RTL and testbench



---
 rtl/seq_signed_unsigned_divider.sv | 208 ++++++++++++++++++++
 tb/tb_seq_signed_unsigned_divider.sv | 351 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/seq_signed_unsigned_divider.sv
// -----------------------------------------------------------------------------
// seq_signed_unsigned_divider
//
// Multi-cycle restoring divider: DIVIDEND_W-bit dividend by DIVISOR_W-bit
// divisor, one quotient bit per clock. A start in IDLE latches the operands,
// DIVIDEND_W RUN cycles resolve the quotient bits MSB first, and one FIX cycle
// applies signs, registers the results and pulses done. Latency is fixed at
// DIVIDEND_W+1 edges after the start edge, independent of the operand values.
//
// Build option:
//   DIVIDER_SIGNED_EN - when defined, signed_mode selects two's-complement
//                       operands (truncating quotient, remainder takes the
//                       dividend sign, min/-1 raises overflow). When undefined,
//                       signed_mode is ignored, operands are unsigned and
//                       overflow stays 0.
//
// Ports:
//   clk          in   rising-edge clock
//   rst_n        in   asynchronous active-low reset
//   start        in   request, sampled only in IDLE
//   signed_mode  in   1 = two's-complement operands, sampled with start
//   dividend     in   numerator, sampled with start
//   divisor      in   denominator, sampled with start
//   busy         out  high while an operation is in flight
//   done         out  one-cycle pulse when the result registers update
//   quotient     out  registered quotient
//   remainder    out  registered remainder
//   div_by_zero  out  last operation had divisor == 0
//   overflow     out  last operation was signed min / -1
// -----------------------------------------------------------------------------
module seq_signed_unsigned_divider #(
  parameter int DIVIDEND_W = 8,
  parameter int DIVISOR_W  = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  signed_mode,
  input  logic [DIVIDEND_W-1:0] dividend,
  input  logic [DIVISOR_W-1:0]  divisor,
  output logic                  busy,
  output logic                  done,
  output logic [DIVIDEND_W-1:0] quotient,
  output logic [DIVISOR_W-1:0]  remainder,
  output logic                  div_by_zero,
  output logic                  overflow
);

  localparam int CNT_W = $clog2(DIVIDEND_W + 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DIVIDEND_W - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIX  = 2'd2
  } state_t;

  state_t                  state;
  logic [CNT_W-1:0]        cnt;
  // Dividend bits shift out of the MSB while quotient bits shift into the LSB,
  // so after DIVIDEND_W iterations this register holds the quotient magnitude.
  logic [DIVIDEND_W-1:0]   dvd_q;
  logic [DIVISOR_W-1:0]    dvs_mag;
  logic [DIVISOR_W-1:0]    prem;
  logic                    dbz_pend;

  // Trial subtraction on the DIVISOR_W+1 bit partial remainder.
  logic [DIVISOR_W:0]      shifted;
  logic [DIVISOR_W:0]      trial;
  logic                    borrow;

  // trial's top bit is only non-zero for a zero divisor, whose remainder is
  // forced to 0 at FIX; signed_mode has no effect in the unsigned-only build.
  logic [1:0]              spare_unused;

`ifdef DIVIDER_SIGNED_EN
  logic                    q_neg;
  logic                    r_neg;
  logic                    ovf_pend;

  // Two's-complement negation of a dividend/quotient-width value.
  function automatic logic [DIVIDEND_W-1:0] neg_dvd(input logic [DIVIDEND_W-1:0] v);
    return (~v) + {{(DIVIDEND_W-1){1'b0}}, 1'b1};
  endfunction

  // Two's-complement negation of a divisor/remainder-width value.
  function automatic logic [DIVISOR_W-1:0] neg_dvs(input logic [DIVISOR_W-1:0] v);
    return (~v) + {{(DIVISOR_W-1){1'b0}}, 1'b1};
  endfunction
`endif

  // Shift in the next dividend bit and trial-subtract the divisor magnitude.
  always_comb begin
    shifted = {prem, dvd_q[DIVIDEND_W-1]};
    {borrow, trial} = {1'b0, shifted} - {2'b00, dvs_mag};
  end

  assign spare_unused = {signed_mode, trial[DIVISOR_W]};

  // Control FSM, iteration datapath and registered result outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      cnt         <= {CNT_W{1'b0}};
      dvd_q       <= {DIVIDEND_W{1'b0}};
      dvs_mag     <= {DIVISOR_W{1'b0}};
      prem        <= {DIVISOR_W{1'b0}};
      dbz_pend    <= 1'b0;
`ifdef DIVIDER_SIGNED_EN
      q_neg       <= 1'b0;
      r_neg       <= 1'b0;
      ovf_pend    <= 1'b0;
`endif
      busy        <= 1'b0;
      done        <= 1'b0;
      quotient    <= {DIVIDEND_W{1'b0}};
      remainder   <= {DIVISOR_W{1'b0}};
      div_by_zero <= 1'b0;
      overflow    <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            cnt      <= {CNT_W{1'b0}};
            prem     <= {DIVISOR_W{1'b0}};
            dbz_pend <= (divisor == {DIVISOR_W{1'b0}});
`ifdef DIVIDER_SIGNED_EN
            if (signed_mode) begin
              // Divide magnitudes; signs are re-applied at FIX.
              dvd_q    <= dividend[DIVIDEND_W-1] ? neg_dvd(dividend) : dividend;
              dvs_mag  <= divisor[DIVISOR_W-1] ? neg_dvs(divisor) : divisor;
              q_neg    <= dividend[DIVIDEND_W-1] ^ divisor[DIVISOR_W-1];
              r_neg    <= dividend[DIVIDEND_W-1];
              ovf_pend <= (dividend == {1'b1, {(DIVIDEND_W-1){1'b0}}}) &&
                          (divisor == {DIVISOR_W{1'b1}});
            end else begin
              dvd_q    <= dividend;
              dvs_mag  <= divisor;
              q_neg    <= 1'b0;
              r_neg    <= 1'b0;
              ovf_pend <= 1'b0;
            end
`else
            dvd_q    <= dividend;
            dvs_mag  <= divisor;
`endif
            busy  <= 1'b1;
            state <= RUN;
          end else begin
            state <= IDLE;
          end
        end

        RUN: begin
          if (!borrow) begin
            prem  <= trial[DIVISOR_W-1:0];
            dvd_q <= {dvd_q[DIVIDEND_W-2:0], 1'b1};
          end else begin
            // Restore: a failed trial leaves shifted < divisor, so it fits.
            prem  <= shifted[DIVISOR_W-1:0];
            dvd_q <= {dvd_q[DIVIDEND_W-2:0], 1'b0};
          end
          cnt <= cnt + CNT_ONE;
          if (cnt == LAST_CNT) begin
            state <= FIX;
          end else begin
            state <= RUN;
          end
        end

        FIX: begin
          if (dbz_pend) begin
            // Override whatever the iterations produced for a zero divisor.
            quotient  <= {DIVIDEND_W{1'b1}};
            remainder <= {DIVISOR_W{1'b0}};
          end else begin
`ifdef DIVIDER_SIGNED_EN
            // min / -1 needs no special case: magnitude 2^(W-1) with a
            // positive sign already wraps to the required pattern.
            quotient  <= q_neg ? neg_dvd(dvd_q) : dvd_q;
            remainder <= r_neg ? neg_dvs(prem) : prem;
`else
            quotient  <= dvd_q;
            remainder <= prem;
`endif
          end
          div_by_zero <= dbz_pend;
`ifdef DIVIDER_SIGNED_EN
          overflow    <= ovf_pend;
`else
          overflow    <= 1'b0;
`endif
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= IDLE;
        end

        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seq_signed_unsigned_divider.sv
// -----------------------------------------------------------------------------
// Self-checking bench for seq_signed_unsigned_divider (default parameters).
// Expected results come from an integer-arithmetic model and are queued when
// each request is issued, then popped when done is observed.
// -----------------------------------------------------------------------------
module tb_seq_signed_unsigned_divider;

`ifdef DIVIDER_SIGNED_EN
  localparam bit SIGNED_EN = 1'b1;
`else
  localparam bit SIGNED_EN = 1'b0;
`endif
  localparam int LATENCY = 9;
  localparam int WAIT_LIMIT = 30;

  typedef struct packed {
    logic [7:0] q;
    logic [3:0] r;
    logic       dbz;
    logic       ovf;
  } res_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       smode = 1'b0;
  logic [7:0] dvd = 8'h00;
  logic [3:0] dvs = 4'h0;
  logic       busy;
  logic       done;
  logic [7:0] quotient;
  logic [3:0] remainder;
  logic       div_by_zero;
  logic       overflow;

  res_t exp_q[$];
  int   checks = 0;
  int   fails = 0;

  seq_signed_unsigned_divider #(.DIVIDEND_W(8), .DIVISOR_W(4)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .signed_mode (smode),
    .dividend    (dvd),
    .divisor     (dvs),
    .busy        (busy),
    .done        (done),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero),
    .overflow    (overflow)
  );

  always #5 clk = ~clk;

  function automatic res_t model(input logic sm, input logic [7:0] a, input logic [3:0] b);
    res_t e;
    int na, nb, qi, ri;
    if (sm && SIGNED_EN) begin
      na = int'($signed(a));
      nb = int'($signed(b));
    end else begin
      na = int'(a);
      nb = int'(b);
    end
    if (nb == 0) begin
      e = {8'hFF, 4'h0, 1'b1, 1'b0};
    end else if (na == -128 && nb == -1) begin
      e = {8'h80, 4'h0, 1'b0, 1'b1};
    end else begin
      qi = na / nb;
      ri = na % nb;
      e = {qi[7:0], ri[3:0], 1'b0, 1'b0};
    end
    return e;
  endfunction

  function automatic res_t observed();
    return {quotient, remainder, div_by_zero, overflow};
  endfunction

  function automatic string fmt(input res_t v);
    return $sformatf("q=%h r=%h dz=%b ov=%b", v.q, v.r, v.dbz, v.ovf);
  endfunction

  function automatic res_t pop_exp();
    res_t e;
    if (exp_q.size() == 0) begin
      e = '1;
    end else begin
      e = exp_q.pop_front();
    end
    return e;
  endfunction

  // Called at a negedge: holds start for one active edge (E0), returns at the
  // negedge after E0.
  task automatic start_op(input logic sm, input logic [7:0] a, input logic [3:0] b, input bit track);
    start = 1'b1;
    smode = sm;
    dvd   = a;
    dvs   = b;
    if (track) exp_q.push_back(model(sm, a, b));
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
  endtask

  // Counts active edges until done is seen at a negedge, bounded.
  task automatic wait_done(output int cyc);
    cyc = 0;
    while (done !== 1'b1 && cyc < WAIT_LIMIT) begin
      @(posedge clk);
      cyc++;
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    checks++;
    if ({busy, done, quotient, remainder, div_by_zero, overflow} !== 16'h0000) begin
      fails++;
      $display("FAIL reset_state: got %h, expected 0000",
               {busy, done, quotient, remainder, div_by_zero, overflow});
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_unsigned();
    int cyc;
    res_t e;
    start_op(1'b0, 8'd200, 4'd7, 1'b1);
    checks++;
    if (busy !== 1'b1) begin
      fails++;
      $display("FAIL unsigned_busy: busy=%b after start edge, expected 1", busy);
    end
    wait_done(cyc);
    checks++;
    if (cyc !== LATENCY) begin
      fails++;
      $display("FAIL unsigned_latency: done after %0d edges, expected %0d", cyc, LATENCY);
    end
    e = pop_exp();
    checks++;
    if (observed() !== e || e !== {8'h1C, 4'h4, 1'b0, 1'b0}) begin
      fails++;
      $display("FAIL unsigned_200_7: got %s, expected %s", fmt(observed()), fmt(e));
    end
    @(negedge clk);
    checks++;
    if (done !== 1'b0 || busy !== 1'b0 || quotient !== 8'h1C) begin
      fails++;
      $display("FAIL done_pulse: done=%b busy=%b q=%h one cycle later, expected 0 0 1c",
               done, busy, quotient);
    end
  endtask

  task automatic test_signed();
    int cyc;
    res_t e;
    logic [7:0] a_tab [2];
    logic [3:0] b_tab [2];
    a_tab[0] = 8'h9C; b_tab[0] = 4'h7;
    a_tab[1] = 8'd100; b_tab[1] = 4'h8;
    for (int i = 0; i < 2; i++) begin
      start_op(1'b1, a_tab[i], b_tab[i], 1'b1);
      wait_done(cyc);
      checks++;
      if (cyc !== LATENCY) begin
        fails++;
        $display("FAIL signed_latency_%0d: %0d edges, expected %0d", i, cyc, LATENCY);
      end
      e = pop_exp();
      checks++;
      if (observed() !== e) begin
        fails++;
        $display("FAIL signed_%0d: got %s, expected %s", i, fmt(observed()), fmt(e));
      end
    end
  endtask

  task automatic test_overflow();
    int cyc;
    res_t e;
    start_op(1'b1, 8'h80, 4'hF, 1'b1);
    wait_done(cyc);
    checks++;
    if (cyc !== LATENCY) begin
      fails++;
      $display("FAIL overflow_latency: %0d edges, expected %0d", cyc, LATENCY);
    end
    e = pop_exp();
    checks++;
    if (observed() !== e) begin
      fails++;
      $display("FAIL overflow_min_neg1: got %s, expected %s", fmt(observed()), fmt(e));
    end
  endtask

  task automatic test_div_zero();
    int cyc;
    res_t e;
    for (int m = 0; m < 2; m++) begin
      start_op(m[0], 8'h55, 4'h0, 1'b1);
      wait_done(cyc);
      checks++;
      if (cyc !== LATENCY) begin
        fails++;
        $display("FAIL divzero_latency_m%0d: %0d edges, expected %0d", m, cyc, LATENCY);
      end
      e = pop_exp();
      checks++;
      if (observed() !== e || e !== {8'hFF, 4'h0, 1'b1, 1'b0}) begin
        fails++;
        $display("FAIL divzero_m%0d: got %s, expected %s", m, fmt(observed()), fmt(e));
      end
    end
  endtask

  task automatic test_busy_ignore();
    int cyc;
    int bad;
    res_t e;
    start_op(1'b0, 8'd99, 4'd5, 1'b1);
    repeat (2) @(negedge clk);
    start = 1'b1;
    smode = 1'b1;
    dvd   = 8'h12;
    dvs   = 4'h3;
    @(negedge clk);
    start = 1'b0;
    wait_done(cyc);
    e = pop_exp();
    checks++;
    if (observed() !== e) begin
      fails++;
      $display("FAIL busy_ignore_result: got %s, expected %s", fmt(observed()), fmt(e));
    end
    bad = 0;
    repeat (12) begin
      @(negedge clk);
      if (done !== 1'b0 || busy !== 1'b0) bad++;
    end
    checks++;
    if (bad !== 0) begin
      fails++;
      $display("FAIL busy_ignore_queued: %0d cycles with busy/done after result, expected 0", bad);
    end
  endtask

  task automatic test_reset_abort();
    int cyc;
    int bad;
    res_t e;
    start_op(1'b0, 8'hC8, 4'd7, 1'b0);
    repeat (5) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    checks++;
    if ({busy, done, quotient, remainder, div_by_zero, overflow} !== 16'h0000) begin
      fails++;
      $display("FAIL reset_abort_outputs: got %h, expected 0000",
               {busy, done, quotient, remainder, div_by_zero, overflow});
    end
    bad = 0;
    repeat (6) begin
      @(negedge clk);
      if (done !== 1'b0) bad++;
    end
    rst_n = 1'b1;
    repeat (12) begin
      @(negedge clk);
      if (done !== 1'b0 || busy !== 1'b0) bad++;
    end
    checks++;
    if (bad !== 0) begin
      fails++;
      $display("FAIL reset_abort_done: %0d cycles with done/busy after abort, expected 0", bad);
    end
    start_op(1'b0, 8'd15, 4'd3, 1'b1);
    wait_done(cyc);
    checks++;
    if (cyc !== LATENCY) begin
      fails++;
      $display("FAIL post_reset_latency: %0d edges, expected %0d", cyc, LATENCY);
    end
    e = pop_exp();
    checks++;
    if (observed() !== e || e !== {8'h05, 4'h0, 1'b0, 1'b0}) begin
      fails++;
      $display("FAIL post_reset_15_3: got %s, expected %s", fmt(observed()), fmt(e));
    end
  endtask

  // Each start is driven in the cycle where the previous done is high.
  task automatic test_back_to_back();
    int cyc;
    res_t e;
    logic       sm;
    logic [7:0] a;
    logic [3:0] b;
    logic [12:0] tab [6];
    tab[0] = {1'b1, 8'h80, 4'h1};
    tab[1] = {1'b1, 8'h7F, 4'h8};
    tab[2] = {1'b0, 8'hFF, 4'hF};
    tab[3] = {1'b0, 8'h00, 4'h5};
    tab[4] = {1'b1, 8'hF9, 4'h2};
    tab[5] = {1'b0, 8'h0E, 4'h1};
    for (int i = 0; i < 16; i++) begin
      if (i < 6) begin
        {sm, a, b} = tab[i];
      end else begin
        sm = 1'($urandom_range(0, 1));
        a  = 8'($urandom_range(0, 255));
        b  = 4'($urandom_range(0, 15));
      end
      start_op(sm, a, b, 1'b1);
      wait_done(cyc);
      checks++;
      if (cyc !== LATENCY) begin
        fails++;
        $display("FAIL b2b_latency_%0d: %0d edges, expected %0d", i, cyc, LATENCY);
      end
      e = pop_exp();
      checks++;
      if (observed() !== e) begin
        fails++;
        $display("FAIL b2b_%0d (sm=%b a=%h b=%h): got %s, expected %s",
                 i, sm, a, b, fmt(observed()), fmt(e));
      end
    end
  endtask

  initial begin
    test_reset();
    test_unsigned();
    test_signed();
    test_overflow();
    test_div_zero();
    test_busy_ignore();
    test_reset_abort();
    test_back_to_back();
    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end

endmodule
